// File: rtl/axis_gain_offset_pipe.sv
// Two-stage AXI-stream pixel stage: sat((tdata*gain)>>FRAC_W + offset) or bypass,
// with config latched at start-of-frame, line-length checking and frame/error counters.
module axis_gain_offset_pipe #(
  parameter int DATA_W   = 16,
  parameter int USER_W   = 2,
  parameter int CTRL_W   = 16,
  parameter int FRAC_W   = 3,
  parameter int LINE_LEN = 100,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bypass,
  input  logic [CTRL_W-1:0] ctrl1,
  input  logic [CTRL_W-1:0] ctrl2,
  input  logic              ififo_valid,
  output logic              ififo_ready,
  input  logic [DATA_W-1:0] ififo_tdata,
  input  logic              ififo_tlast,
  input  logic [USER_W-1:0] ififo_tuser,
  output logic              ofifo_valid,
  input  logic              ofifo_ready,
  output logic [DATA_W-1:0] ofifo_tdata,
  output logic              ofifo_tlast,
  output logic [USER_W-1:0] ofifo_tuser,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int PROD_W = DATA_W + CTRL_W;
  localparam int SUM_W  = PROD_W - FRAC_W + 1;
  localparam int IDX_W  = $clog2(LINE_LEN + 1);
  localparam logic [CTRL_W-1:0] UNITY   = CTRL_W'(1) << FRAC_W;
  localparam logic [SUM_W-1:0]  SAT_MAX = {{(SUM_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  // Handshake: a beat transfers on a rising edge where valid & ready are both 1;
  // valid never depends on ready, and a raised ofifo_valid holds with stable
  // payload until ofifo_ready accepts it. The whole pipe moves on one enable.
  logic en;
  logic accept;
  logic sof;

  assign en          = ofifo_ready | ~ofifo_valid;
  assign ififo_ready = en;
  assign accept      = ififo_valid & en;
  assign sof         = ififo_tuser[0];

  // Shadow configuration, reloaded only by an accepted SOF beat
  logic              sh_bypass;
  logic [CTRL_W-1:0] sh_gain;
  logic [CTRL_W-1:0] sh_offset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_bypass <= 1'b0;
      sh_gain   <= UNITY;
      sh_offset <= '0;
    end else if (accept && sof) begin
      sh_bypass <= bypass;
      sh_gain   <= ctrl1;
      sh_offset <= ctrl2;
    end
  end

  // The SOF beat itself uses the values being latched alongside it
  logic              eff_bypass;
  logic [CTRL_W-1:0] eff_gain;
  logic [CTRL_W-1:0] eff_offset;

  always_comb begin
    eff_bypass = sh_bypass;
    eff_gain   = sh_gain;
    eff_offset = sh_offset;
    if (sof) begin
      eff_bypass = bypass;
      eff_gain   = ctrl1;
      eff_offset = ctrl2;
    end
  end

  // Stage 1: multiply; offset and mode travel with the beat
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [PROD_W-1:0] s1_prod;
  logic              s1_bypass;
  logic [CTRL_W-1:0] s1_offset;
  logic              s1_tlast;
  logic [USER_W-1:0] s1_tuser;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_prod   <= '0;
      s1_bypass <= 1'b0;
      s1_offset <= '0;
      s1_tlast  <= 1'b0;
      s1_tuser  <= '0;
    end else if (en) begin
      s1_valid  <= ififo_valid;
      s1_data   <= ififo_tdata;
      s1_prod   <= PROD_W'(ififo_tdata) * PROD_W'(eff_gain);
      s1_bypass <= eff_bypass;
      s1_offset <= eff_offset;
      s1_tlast  <= ififo_tlast;
      s1_tuser  <= ififo_tuser;
    end
  end

  // Stage 2: scale down, add offset with a guard bit, clamp instead of wrapping
  logic [SUM_W-1:0]  sum;
  logic [DATA_W-1:0] result;

  always_comb begin
    sum = SUM_W'(s1_prod >> FRAC_W) + SUM_W'(s1_offset);
    if (s1_bypass) begin
      result = s1_data;
    end else if (sum > SAT_MAX) begin
      result = '1;
    end else begin
      result = sum[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ofifo_valid <= 1'b0;
      ofifo_tdata <= '0;
      ofifo_tlast <= 1'b0;
      ofifo_tuser <= '0;
    end else if (en) begin
      ofifo_valid <= s1_valid;
      ofifo_tdata <= result;
      ofifo_tlast <= s1_tlast;
      ofifo_tuser <= s1_tuser;
    end
  end

  // Line-length check on accepted input beats; SOF restarts the line
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] pos;
  logic             last_pos;
  logic             len_err;
  logic [IDX_W-1:0] idx_nxt;

  always_comb begin
    cur_idx  = sof ? '0 : idx;
    pos      = cur_idx + IDX_W'(1);
    last_pos = (pos == IDX_W'(LINE_LEN));
    len_err  = ififo_tlast ^ last_pos;
    idx_nxt  = (ififo_tlast || last_pos) ? '0 : pos;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx     <= '0;
      err_cnt <= '0;
    end else if (accept) begin
      idx <= idx_nxt;
      if (len_err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt <= '0;
    end else if (ofifo_valid && ofifo_ready && ofifo_tuser[0]) begin
      frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_axis_gain_offset_pipe.sv
// Bench for axis_gain_offset_pipe: random streams against an arithmetic reference
// model, with latency, stall-stability, counter and reset scenarios.
module tb_axis_gain_offset_pipe;

  localparam int LINE_LEN = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        bypass;
  logic [15:0] ctrl1;
  logic [15:0] ctrl2;
  logic        ififo_valid;
  logic        ififo_ready;
  logic [15:0] ififo_tdata;
  logic        ififo_tlast;
  logic [1:0]  ififo_tuser;
  logic        ofifo_valid;
  logic        ofifo_ready;
  logic [15:0] ofifo_tdata;
  logic        ofifo_tlast;
  logic [1:0]  ofifo_tuser;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  axis_gain_offset_pipe #(
    .DATA_W(16), .USER_W(2), .CTRL_W(16), .FRAC_W(3), .LINE_LEN(LINE_LEN), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .bypass(bypass), .ctrl1(ctrl1), .ctrl2(ctrl2),
    .ififo_valid(ififo_valid), .ififo_ready(ififo_ready), .ififo_tdata(ififo_tdata),
    .ififo_tlast(ififo_tlast), .ififo_tuser(ififo_tuser),
    .ofifo_valid(ofifo_valid), .ofifo_ready(ofifo_ready), .ofifo_tdata(ofifo_tdata),
    .ofifo_tlast(ofifo_tlast), .ofifo_tuser(ofifo_tuser),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [18:0] exp_q[$];   // {tuser, tlast, tdata}
  int          acc_q[$];   // cycle of acceptance, for latency checks
  bit          lat_check = 1'b0;
  int          ready_mode = 0;  // 0: always ready, 1: random, 2: never ready

  // reference model: configuration seen by the stream, line position, counters
  bit m_bypass;
  int m_gain;
  int m_off;
  int m_idx;
  int m_err;
  int m_frames;

  function automatic logic [15:0] model_pixel(input logic [15:0] d, input bit byp,
                                              input int g, input int off);
    longint unsigned s;
    if (byp) return d;
    s = ((longint'(d) * longint'(g)) / 8) + longint'(off);
    if (s > 65535) s = 65535;
    return s[15:0];
  endfunction

  task automatic model_reset();
    m_bypass = 1'b0; m_gain = 8; m_off = 0; m_idx = 0; m_err = 0; m_frames = 0;
    exp_q.delete();
    acc_q.delete();
  endtask

  task automatic model_accept(input logic [15:0] d, input logic last, input logic [1:0] user);
    int p;
    if (user[0]) begin
      m_bypass = bypass; m_gain = ctrl1; m_off = ctrl2; m_idx = 0;
    end
    p = m_idx + 1;
    if (last && p != LINE_LEN) m_err++;
    else if (!last && p == LINE_LEN) m_err++;
    m_idx = (last || p == LINE_LEN) ? 0 : p;
    if (m_err > 65535) m_err = 65535;
    exp_q.push_back({user, last, model_pixel(d, m_bypass, m_gain, m_off)});
    acc_q.push_back(cyc);
  endtask

  // ---------------- output monitor ----------------
  logic        prev_stall = 1'b0;
  logic [18:0] prev_out;

  always @(negedge clk) begin
    logic [18:0] e;
    int          a;
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (ofifo_valid !== 1'b1 || {ofifo_tuser, ofifo_tlast, ofifo_tdata} !== prev_out) begin
          errors++;
          $display("FAIL stall_hold got valid=%b beat=%h exp valid=1 beat=%h",
                   ofifo_valid, {ofifo_tuser, ofifo_tlast, ofifo_tdata}, prev_out);
        end
      end
      prev_stall = ofifo_valid && !ofifo_ready;
      prev_out   = {ofifo_tuser, ofifo_tlast, ofifo_tdata};
      if (ofifo_valid === 1'b1 && ofifo_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat got %h exp none", {ofifo_tuser, ofifo_tlast, ofifo_tdata});
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          if ({ofifo_tuser, ofifo_tlast, ofifo_tdata} !== e) begin
            errors++;
            $display("FAIL out_beat got %h exp %h", {ofifo_tuser, ofifo_tlast, ofifo_tdata}, e);
          end
          if (lat_check) begin
            checks++;
            if (cyc - a != 2) begin
              errors++;
              $display("FAIL latency got %0d exp 2", cyc - a);
            end
          end
          if (e[17]) m_frames++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1:       ofifo_ready = 1'($urandom_range(0, 1));
        2:       ofifo_ready = 1'b0;
        default: ofifo_ready = 1'b1;
      endcase
    end
  end

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [15:0] d, input logic last, input logic [1:0] user,
                           input int gap_max);
    bit done = 1'b0;
    ififo_valid = 1'b0;
    repeat ($urandom_range(0, gap_max)) begin
      @(posedge clk);
      #1;
    end
    ififo_valid = 1'b1;
    ififo_tdata = d;
    ififo_tlast = last;
    ififo_tuser = user;
    for (int k = 0; k < 2000 && !done; k++) begin
      @(negedge clk);
      if (ififo_ready) begin
        model_accept(d, last, user);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    ififo_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got ready=%b exp 1", ififo_ready);
    end
  endtask

  // random-data line of n beats; tlast on beat n
  task automatic send_line(input int n, input bit with_sof, input int gap_max);
    for (int i = 0; i < n; i++) begin
      send_beat(16'($urandom_range(0, 65535)), i == n - 1,
                {1'($urandom_range(0, 1)), with_sof && i == 0}, gap_max);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 3000 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending exp 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    checks += 7;
    if (ofifo_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", ofifo_valid); end
    if (ofifo_tdata !== 16'h0) begin errors++; $display("FAIL rst_tdata got %h exp 0", ofifo_tdata); end
    if (ofifo_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast got %b exp 0", ofifo_tlast); end
    if (ofifo_tuser !== 2'b0) begin errors++; $display("FAIL rst_tuser got %b exp 0", ofifo_tuser); end
    if (frame_cnt !== 16'h0) begin errors++; $display("FAIL rst_frame_cnt got %0d exp 0", frame_cnt); end
    if (err_cnt !== 16'h0) begin errors++; $display("FAIL rst_err_cnt got %0d exp 0", err_cnt); end
    if (ififo_ready !== 1'b1) begin errors++; $display("FAIL rst_ififo_ready got %b exp 1", ififo_ready); end
    release_reset();
  endtask

  task automatic test_identity();
    ready_mode = 0; lat_check = 1'b1;
    bypass = 1'b0; ctrl1 = 16'd8; ctrl2 = 16'd0;
    for (int i = 0; i < LINE_LEN; i++) begin
      send_beat(16'(i), i == LINE_LEN - 1, {1'($urandom_range(0, 1)), i == 0}, 0);
    end
    drain();
    checks += 2;
    if (frame_cnt !== 16'(m_frames)) begin errors++; $display("FAIL id_frame_cnt got %0d exp %0d", frame_cnt, m_frames); end
    if (err_cnt !== 16'(m_err)) begin errors++; $display("FAIL id_err_cnt got %0d exp %0d", err_cnt, m_err); end
    lat_check = 1'b0;
  endtask

  task automatic test_gain_offset();
    ready_mode = 0; lat_check = 1'b1;
    bypass = 1'b0; ctrl1 = 16'd10; ctrl2 = 16'd5;
    send_beat(16'd100, 1'b0, 2'b01, 0);
    send_beat(16'hFFFF, 1'b0, 2'b00, 0);
    for (int i = 2; i < LINE_LEN; i++) begin
      send_beat(16'($urandom_range(0, 65535)), i == LINE_LEN - 1, 2'b00, 1);
    end
    drain();
    checks++;
    if (err_cnt !== 16'(m_err)) begin errors++; $display("FAIL go_err_cnt got %0d exp %0d", err_cnt, m_err); end
    lat_check = 1'b0;
  endtask

  task automatic test_sof_latch();
    ready_mode = 0;
    bypass = 1'b0; ctrl1 = 16'd8; ctrl2 = 16'd0;
    for (int i = 0; i < LINE_LEN; i++) begin
      if (i == 50) begin ctrl1 = 16'd10; ctrl2 = 16'd7; end
      send_beat(16'($urandom_range(0, 50000)), i == LINE_LEN - 1, {1'b0, i == 0}, 1);
    end
    ctrl2 = 16'd0;
    send_line(LINE_LEN, 1'b1, 1);
    drain();
    checks++;
    if (frame_cnt !== 16'(m_frames)) begin errors++; $display("FAIL sof_frame_cnt got %0d exp %0d", frame_cnt, m_frames); end
  endtask

  task automatic test_bypass();
    ready_mode = 0; lat_check = 1'b1;
    bypass = 1'b1; ctrl1 = 16'd10; ctrl2 = 16'd3;
    send_line(LINE_LEN, 1'b1, 1);
    drain();
    lat_check = 1'b0;
    bypass = 1'b0;
  endtask

  task automatic test_back_to_back();
    ready_mode = 1;
    for (int f = 0; f < 3; f++) begin
      bypass = 1'($urandom_range(0, 1));
      ctrl1  = 16'($urandom_range(0, 65535));
      ctrl2  = 16'($urandom_range(0, 65535));
      for (int i = 0; i < LINE_LEN; i++) begin
        if (i == 30) begin
          bypass = ~bypass; ctrl1 = 16'($urandom_range(0, 65535)); ctrl2 = 16'($urandom_range(0, 65535));
        end
        send_beat(16'($urandom_range(0, 65535)), i == LINE_LEN - 1, {1'($urandom_range(0, 1)), i == 0}, 2);
      end
    end
    drain();
    ready_mode = 0;
    checks += 2;
    if (frame_cnt !== 16'(m_frames)) begin errors++; $display("FAIL bp_frame_cnt got %0d exp %0d", frame_cnt, m_frames); end
    if (err_cnt !== 16'(m_err)) begin errors++; $display("FAIL bp_err_cnt got %0d exp %0d", err_cnt, m_err); end
  endtask

  task automatic test_length_reset();
    ready_mode = 0;
    bypass = 1'b0; ctrl1 = 16'd8; ctrl2 = 16'd0;
    send_line(LINE_LEN - 1, 1'b1, 0);
    send_line(LINE_LEN + 1, 1'b0, 0);
    drain();
    checks++;
    if (err_cnt !== 16'(m_err)) begin errors++; $display("FAIL len_err_cnt got %0d exp %0d", err_cnt, m_err); end
    // partial frame left in flight, then reset mid-line
    send_line(40, 1'b1, 0);
    ififo_valid = 1'b1;
    ififo_tdata = 16'h1234;
    ififo_tlast = 1'b0;
    ififo_tuser = 2'b00;
    ready_mode = 2;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    ififo_valid = 1'b0;
    #2;
    checks += 6;
    if (ofifo_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", ofifo_valid); end
    if (ofifo_tdata !== 16'h0) begin errors++; $display("FAIL mid_rst_tdata got %h exp 0", ofifo_tdata); end
    if (ofifo_tlast !== 1'b0 || ofifo_tuser !== 2'b0) begin
      errors++; $display("FAIL mid_rst_side got %b%b exp 000", ofifo_tuser, ofifo_tlast);
    end
    if (frame_cnt !== 16'h0) begin errors++; $display("FAIL mid_rst_frame_cnt got %0d exp 0", frame_cnt); end
    if (err_cnt !== 16'h0) begin errors++; $display("FAIL mid_rst_err_cnt got %0d exp 0", err_cnt); end
    if (ififo_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b exp 1", ififo_ready); end
    ready_mode = 0;
    @(posedge clk);
    #1;
    release_reset();
    // first post-reset line carries no SOF: it must start at position 0 with reset config
    ctrl1 = 16'd10; ctrl2 = 16'd9;
    send_line(LINE_LEN, 1'b0, 1);
    send_line(LINE_LEN, 1'b1, 1);
    drain();
    checks += 2;
    if (frame_cnt !== 16'(m_frames)) begin errors++; $display("FAIL post_rst_frame_cnt got %0d exp %0d", frame_cnt, m_frames); end
    if (err_cnt !== 16'(m_err)) begin errors++; $display("FAIL post_rst_err_cnt got %0d exp %0d", err_cnt, m_err); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b0;
    bypass = 1'b0; ctrl1 = 16'd8; ctrl2 = 16'd0;
    ififo_valid = 1'b0; ififo_tdata = '0; ififo_tlast = 1'b0; ififo_tuser = '0;
    ofifo_ready = 1'b1;
    model_reset();
    test_reset();
    test_identity();
    test_gain_offset();
    test_sof_latch();
    test_bypass();
    test_back_to_back();
    test_length_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    checks++;
    errors++;
    $display("FAIL watchdog got timeout exp completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
